// File: rtl/simon_pkg.sv
// Shared constants and types for the Simon Says display path: screen geometry,
// pad placement and colours, and the draw sequencer states.
package simon_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  // Pads sit in a 2x2 grid: index bit 0 selects the column, bit 1 the row.
  localparam logic [7:0] PAD_ORIGIN_X [4] = '{8'd40, 8'd88, 8'd40, 8'd88};
  localparam logic [6:0] PAD_ORIGIN_Y [4] = '{7'd20, 7'd20, 7'd68, 7'd68};
  localparam logic [2:0] PAD_COLOUR   [4] = '{3'b010, 3'b100, 3'b110, 3'b001};

  localparam logic [2:0] COLOUR_UNLIT = 3'b111;
  localparam logic [2:0] COLOUR_BLACK = 3'b000;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    DONE
  } state_e;

endpackage

// File: rtl/rect_scanner.sv
// Raster-order column/row counter over a width x height rectangle; col/row name
// the pixel currently presented, and last flags the bottom-right pixel.
module rect_scanner (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic [7:0] width,
  input  logic [6:0] height,
  output logic [7:0] col,
  output logic [6:0] row,
  output logic       active,
  output logic       last
);

  logic [7:0] col_q, col_d;
  logic [6:0] row_q, row_d;
  logic       active_q, active_d;
  logic       col_end;

  assign col_end = (col_q == width - 8'd1);
  assign last    = active_q && col_end && (row_q == height - 7'd1);

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    active_d = active_q;
    if (go) begin
      col_d    = '0;
      row_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (last) begin
        col_d    = '0;
        row_d    = '0;
        active_d = 1'b0;
      end else if (col_end) begin
        col_d = '0;
        row_d = row_q + 7'd1;
      end else begin
        col_d = col_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q    <= '0;
      row_q    <= '0;
      active_q <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      active_q <= active_d;
    end
  end

  assign col    = col_q;
  assign row    = row_q;
  assign active = active_q;

endmodule

// File: rtl/pad_draw_ctrl.sv
// Pixel sequencer for the Simon Says board: paints one game pad (lit or unlit)
// or clears the screen, one registered pixel per clock, then pulses done.
module pad_draw_ctrl
  import simon_pkg::*;
#(
  parameter int unsigned PAD_W = 32,
  parameter int unsigned PAD_H = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] pad,
  input  logic       lit,
  input  logic       clear,
  output logic       busy,
  output logic       done,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot
);

  if (PAD_W < 1 || PAD_H < 1 || 88 + PAD_W > SCREEN_W || 68 + PAD_H > SCREEN_H) begin : g_bad_size
    $error("pad_draw_ctrl: PAD_W/PAD_H do not fit the screen");
  end

  state_e     state_q, state_d;
  logic [7:0] origin_x_q, origin_x_d;
  logic [6:0] origin_y_q, origin_y_d;
  logic [7:0] width_q, width_d;
  logic [6:0] height_q, height_d;
  logic [2:0] colour_q, colour_d;
  logic [7:0] x_out_q, x_out_d;
  logic [6:0] y_out_q, y_out_d;
  logic [2:0] colour_out_q, colour_out_d;
  logic       plot_q, plot_d;
  logic       done_q, done_d;

  logic       go;
  logic [7:0] col;
  logic [6:0] row;
  logic       active;
  logic       last;
  logic       col_wrap;

  rect_scanner u_scanner (
    .clk    (clk),
    .reset  (reset),
    .go     (go),
    .width  (width_q),
    .height (height_q),
    .col    (col),
    .row    (row),
    .active (active),
    .last   (last)
  );

  assign col_wrap = (col == width_q - 8'd1);

  // Output registers load the pixel after the scanner's current one, so the
  // acceptance edge itself presents (col 0, row 0) in the following cycle.
  always_comb begin
    state_d      = state_q;
    origin_x_d   = origin_x_q;
    origin_y_d   = origin_y_q;
    width_d      = width_q;
    height_d     = height_q;
    colour_d     = colour_q;
    x_out_d      = x_out_q;
    y_out_d      = y_out_q;
    colour_out_d = colour_out_q;
    plot_d       = 1'b0;
    done_d       = 1'b0;
    go           = 1'b0;

    case (state_q)
      IDLE: begin
        if (clear) begin
          go         = 1'b1;
          origin_x_d = '0;
          origin_y_d = '0;
          width_d    = 8'(SCREEN_W);
          height_d   = 7'(SCREEN_H);
          colour_d   = COLOUR_BLACK;
          state_d    = DRAW;
        end else if (start) begin
          go         = 1'b1;
          origin_x_d = PAD_ORIGIN_X[pad];
          origin_y_d = PAD_ORIGIN_Y[pad];
          width_d    = 8'(PAD_W);
          height_d   = 7'(PAD_H);
          colour_d   = lit ? PAD_COLOUR[pad] : COLOUR_UNLIT;
          state_d    = DRAW;
        end
        if (clear || start) begin
          x_out_d      = origin_x_d;
          y_out_d      = origin_y_d;
          colour_out_d = colour_d;
          plot_d       = 1'b1;
        end
      end
      DRAW: begin
        if (last || !active) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          plot_d  = 1'b1;
          x_out_d = origin_x_q + (col_wrap ? 8'd0 : col + 8'd1);
          y_out_d = origin_y_q + (col_wrap ? row + 7'd1 : row);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      origin_x_q   <= '0;
      origin_y_q   <= '0;
      width_q      <= '0;
      height_q     <= '0;
      colour_q     <= '0;
      x_out_q      <= '0;
      y_out_q      <= '0;
      colour_out_q <= '0;
      plot_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      origin_x_q   <= origin_x_d;
      origin_y_q   <= origin_y_d;
      width_q      <= width_d;
      height_q     <= height_d;
      colour_q     <= colour_d;
      x_out_q      <= x_out_d;
      y_out_q      <= y_out_d;
      colour_out_q <= colour_out_d;
      plot_q       <= plot_d;
      done_q       <= done_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign x_out      = x_out_q;
  assign y_out      = y_out_q;
  assign colour_out = colour_out_q;
  assign plot       = plot_q;

endmodule

// File: tb/tb_pad_draw_ctrl.sv
// Self-checking bench for pad_draw_ctrl: every operation is compared against a
// raster model built from pad geometry and colour rules.
module tb_pad_draw_ctrl;

  localparam int W = 32;
  localparam int H = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] pad = '0;
  logic       lit = 1'b0;
  logic       clear = 1'b0;
  logic       busy, done, plot;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;

  always #5 clk = ~clk;

  pad_draw_ctrl #(.PAD_W(W), .PAD_H(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pad        (pad),
    .lit        (lit),
    .clear      (clear),
    .busy       (busy),
    .done       (done),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour_out (colour_out),
    .plot       (plot)
  );

  int checks = 0;
  int errors = 0;

  // Observations of one operation
  logic [7:0] px[$];
  logic [6:0] py[$];
  logic [2:0] pc[$];
  int n_plot, done_at, first_plot, idle_cyc, viol, done_cnt;
  bit timed_out;
  logic [7:0] done_x;
  logic [6:0] done_y;
  logic [2:0] done_c;

  // Reference model: pads form a 2x2 grid with a 48-pixel pitch.
  function automatic int m_ox(input int p); return 40 + 48 * (p % 2); endfunction
  function automatic int m_oy(input int p); return 20 + 48 * (p / 2); endfunction
  function automatic int m_col(input int p, input bit l);
    if (!l) return 7;
    case (p)
      0: return 2;
      1: return 4;
      2: return 6;
      default: return 1;
    endcase
  endfunction

  task automatic req(input bit s, input bit c, input int p, input bit l, input bit keep);
    @(negedge clk);
    start = s; clear = c; pad = 2'(p); lit = l;
    @(posedge clk);
    #1;
    if (!keep) begin start = 1'b0; clear = 1'b0; end
  endtask

  task automatic collect(input int max_cyc, input int stop_plots, input bit disturb, input bit hold);
    px.delete(); py.delete(); pc.delete();
    n_plot = 0; done_at = 0; first_plot = 0; idle_cyc = 0; viol = 0; done_cnt = 0;
    timed_out = 1'b1;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk);
      if (plot === 1'b1) begin
        px.push_back(x_out); py.push_back(y_out); pc.push_back(colour_out);
        n_plot++;
        if (first_plot == 0) first_plot = k;
      end
      if (busy !== 1'b1) idle_cyc++;
      if ((plot === 1'b1 || done === 1'b1) && busy !== 1'b1) viol++;
      if (plot === 1'b1 && done === 1'b1) viol++;
      if (done === 1'b1) begin
        done_cnt++; done_at = k; done_x = x_out; done_y = y_out; done_c = colour_out;
        timed_out = 1'b0;
        if (!hold) begin start = 1'b0; clear = 1'b0; end
        break;
      end
      if (stop_plots > 0 && n_plot == stop_plots) begin timed_out = 1'b0; break; end
      if (disturb) begin
        start = 1'($urandom_range(0, 1)); clear = 1'($urandom_range(0, 1));
        pad = 2'($urandom); lit = 1'($urandom);
      end
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, plot, x_out, y_out, colour_out} !== '0) begin
        errors++;
        $display("FAIL reset_idle: cycle %0d busy=%0b done=%0b plot=%0b x=%0d y=%0d c=%0d want all 0",
                 i, busy, done, plot, x_out, y_out, colour_out);
      end
    end
  endtask

  task automatic test_pad_draw;
    int p, ox, oy, c, bad;
    bit l;
    for (int d = 0; d < 4; d++) begin
      p = (d == 0) ? 2 : int'($urandom_range(0, 3));
      l = (d == 0) ? 1'b1 : 1'($urandom);
      ox = m_ox(p); oy = m_oy(p); c = m_col(p, l);
      req(1'b1, 1'b0, p, l, 1'b0);
      collect(W * H + 20, 0, 1'b0, 1'b0);
      checks++;
      if (timed_out) begin errors++; $display("FAIL draw_timeout: pad %0d no done", p); end
      checks++;
      if (n_plot !== W * H) begin
        errors++; $display("FAIL draw_count: pad %0d plots %0d want %0d", p, n_plot, W * H);
      end
      checks++;
      if (first_plot !== 1 || done_at !== W * H + 1) begin
        errors++;
        $display("FAIL draw_timing: first %0d done %0d want 1 and %0d", first_plot, done_at, W * H + 1);
      end
      bad = -1;
      for (int i = 0; i < px.size(); i++)
        if (bad < 0 && (px[i] !== 8'(ox + i % W) || py[i] !== 7'(oy + i / W) || pc[i] !== 3'(c)))
          bad = i;
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL draw_pixel: pad %0d idx %0d got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                 p, bad, px[bad], py[bad], pc[bad], ox + bad % W, oy + bad / W, c);
      end
      checks++;
      if (viol !== 0 || idle_cyc !== 0) begin
        errors++; $display("FAIL draw_busy: violations %0d idle %0d want 0 0", viol, idle_cyc);
      end
      checks++;
      if (done_x !== 8'(ox + W - 1) || done_y !== 7'(oy + H - 1) || done_c !== 3'(c)) begin
        errors++;
        $display("FAIL draw_hold: at done (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                 done_x, done_y, done_c, ox + W - 1, oy + H - 1, c);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || plot !== 1'b0) begin
        errors++; $display("FAIL draw_return_idle: busy %0b done %0b plot %0b want 0", busy, done, plot);
      end
    end
  endtask

  task automatic test_clear_priority;
    int bad;
    req(1'b1, 1'b1, 1, 1'b1, 1'b0);
    collect(160 * 120 + 20, 0, 1'b0, 1'b0);
    checks++;
    if (timed_out || n_plot !== 19200 || done_at !== 19201) begin
      errors++;
      $display("FAIL clear_count: plots %0d done %0d timeout %0b want 19200 19201 0", n_plot, done_at, timed_out);
    end
    bad = -1;
    for (int i = 0; i < px.size(); i++)
      if (bad < 0 && (px[i] !== 8'(i % 160) || py[i] !== 7'(i / 160) || pc[i] !== 3'b000)) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL clear_pixel: idx %0d got (%0d,%0d,c%0d) want (%0d,%0d,c0)",
               bad, px[bad], py[bad], pc[bad], bad % 160, bad / 160);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (plot !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL clear_no_followup: cycle %0d plot %0b busy %0b want 0 0", i, plot, busy);
      end
    end
  endtask

  task automatic test_ignore_while_busy;
    int bad;
    req(1'b1, 1'b0, 0, 1'b0, 1'b0);
    collect(W * H + 20, 0, 1'b1, 1'b0);
    checks++;
    if (timed_out || n_plot !== W * H || done_at !== W * H + 1 || done_cnt !== 1) begin
      errors++;
      $display("FAIL busy_ignore_count: plots %0d done %0d want %0d %0d", n_plot, done_at, W * H, W * H + 1);
    end
    bad = -1;
    for (int i = 0; i < px.size(); i++)
      if (bad < 0 && (px[i] !== 8'(40 + i % W) || py[i] !== 7'(20 + i / W) || pc[i] !== 3'b111)) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL busy_ignore_pixel: idx %0d got (%0d,%0d,c%0d) want (%0d,%0d,c7)",
               bad, px[bad], py[bad], pc[bad], 40 + bad % W, 20 + bad / W);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (plot !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL busy_ignore_after: cycle %0d plot %0b done %0b want 0 0", i, plot, done);
      end
    end
  endtask

  task automatic test_reset_mid;
    req(1'b1, 1'b0, 3, 1'b1, 1'b0);
    collect(W * H + 20, 500, 1'b0, 1'b0);
    checks++;
    if (timed_out || n_plot !== 500 || done_cnt !== 0) begin
      errors++; $display("FAIL reset_mid_reach: plots %0d done %0d want 500 0", n_plot, done_cnt);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, done, plot, x_out, y_out, colour_out} !== '0) begin
      errors++;
      $display("FAIL reset_mid_clear: busy %0b done %0b plot %0b x %0d y %0d c %0d want all 0",
               busy, done, plot, x_out, y_out, colour_out);
    end
    collect(6, 0, 1'b0, 1'b0);
    checks++;
    if (done_cnt !== 0 || n_plot !== 0) begin
      errors++; $display("FAIL reset_mid_quiet: done %0d plots %0d want 0 0", done_cnt, n_plot);
    end
    req(1'b1, 1'b0, 3, 1'b1, 1'b0);
    collect(W * H + 20, 0, 1'b0, 1'b0);
    checks++;
    if (timed_out || n_plot !== W * H || px[0] !== 8'd88 || py[0] !== 7'd68 || pc[0] !== 3'b001) begin
      errors++;
      $display("FAIL reset_mid_redraw: plots %0d first (%0d,%0d,c%0d) want %0d (88,68,c1)",
               n_plot, (n_plot > 0) ? px[0] : 0, (n_plot > 0) ? py[0] : 0, (n_plot > 0) ? pc[0] : 0, W * H);
    end
  endtask

  task automatic test_back_to_back;
    bit l;
    l = 1'($urandom);
    req(1'b1, 1'b0, 0, l, 1'b1);
    for (int d = 0; d < 3; d++) begin
      collect(W * H + 20, 0, 1'b0, 1'b1);
      checks++;
      if (timed_out || n_plot !== W * H || done_cnt !== 1) begin
        errors++; $display("FAIL b2b_count: draw %0d plots %0d want %0d", d, n_plot, W * H);
      end
      checks++;
      if (idle_cyc !== ((d == 0) ? 0 : 1) || first_plot !== ((d == 0) ? 1 : 2)
          || done_at !== first_plot + W * H) begin
        errors++;
        $display("FAIL b2b_gap: draw %0d idle %0d first %0d done %0d want %0d %0d first+%0d",
                 d, idle_cyc, first_plot, done_at, (d == 0) ? 0 : 1, (d == 0) ? 1 : 2, W * H);
      end
      checks++;
      if (n_plot == 0 || px[0] !== 8'd40 || py[0] !== 7'd20 || pc[0] !== 3'(m_col(0, l))) begin
        errors++;
        $display("FAIL b2b_first: draw %0d first (%0d,%0d,c%0d) want (40,20,c%0d)",
                 d, (n_plot > 0) ? px[0] : 0, (n_plot > 0) ? py[0] : 0, (n_plot > 0) ? pc[0] : 0, m_col(0, l));
      end
    end
    start = 1'b0;
    collect(5, 0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_pad_draw();
    test_clear_priority();
    test_ignore_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
